// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory stage: op kinds, RV32I load/store width codes, FSM states.
// Decode imports this too so in_kind/in_funct3 encodings live in one place.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        KIND_PASS  = 2'b00,
        KIND_LOAD  = 2'b01,
        KIND_STORE = 2'b10,
        KIND_RSVD  = 2'b11
    } kind_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

    // Unsupported width codes fall back to a full word.
    function automatic size_e f3_size(input logic [2:0] f3);
        size_e r;
        case (f3)
            F3_B, F3_BU: r = SZ_B;
            F3_H, F3_HU: r = SZ_H;
            default:     r = SZ_W;
        endcase
        return r;
    endfunction

    function automatic logic f3_unsigned(input logic [2:0] f3);
        return (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] alo);
        logic r;
        case (f3_size(f3))
            SZ_H:    r = alo[0];
            SZ_W:    r = |alo;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Execute-side, data-memory-side and writeback-side signals of the memory stage.
// slave = the stage itself, master = its environment.
interface mem_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_kind;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [4:0]  in_rd;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic        bus_err;

    modport slave (
        input  in_valid, in_kind, in_funct3, in_addr, in_wdata, in_rd,
        input  mem_ready, mem_rvalid, mem_rdata, out_ready,
        output in_ready, mem_valid, mem_addr, mem_wstrb, mem_wdata,
        output out_valid, out_data, out_rd, bus_err
    );

    modport master (
        output in_valid, in_kind, in_funct3, in_addr, in_wdata, in_rd,
        output mem_ready, mem_rvalid, mem_rdata, out_ready,
        input  in_ready, mem_valid, mem_addr, mem_wstrb, mem_wdata,
        input  out_valid, out_data, out_rd, bus_err
    );
endinterface

// File: rtl/mem_align.sv
// Combinational lane logic: store strobes/lane replication and load byte/half extract with extension.
// Zero latency, no flow control.
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  req_funct3,
    input  logic [1:0]  req_alo,
    input  logic [31:0] req_data,
    output logic [3:0]  req_strb,
    output logic [31:0] req_lanes,
    input  logic [2:0]  rsp_funct3,
    input  logic [1:0]  rsp_alo,
    input  logic [31:0] rsp_rdata,
    output logic [31:0] rsp_data
);

    logic [31:0] byte_shift;
    logic [7:0]  rsp_byte;
    logic [15:0] rsp_half;
    logic        rsp_uns;

    always_comb begin
        req_strb  = 4'b1111;
        req_lanes = req_data;
        case (f3_size(req_funct3))
            SZ_B: begin
                req_strb  = 4'b0001 << req_alo;
                req_lanes = {4{req_data[7:0]}};
            end
            SZ_H: begin
                req_strb  = req_alo[1] ? 4'b1100 : 4'b0011;
                req_lanes = {2{req_data[15:0]}};
            end
            default: begin
                req_strb  = 4'b1111;
                req_lanes = req_data;
            end
        endcase
    end

    assign byte_shift = rsp_rdata >> {rsp_alo, 3'b000};
    assign rsp_byte   = byte_shift[7:0];
    assign rsp_half   = rsp_alo[1] ? rsp_rdata[31:16] : rsp_rdata[15:0];
    assign rsp_uns    = f3_unsigned(rsp_funct3);

    always_comb begin
        rsp_data = rsp_rdata;
        case (f3_size(rsp_funct3))
            SZ_B:    rsp_data = rsp_uns ? {24'b0, rsp_byte} : {{24{rsp_byte[7]}}, rsp_byte};
            SZ_H:    rsp_data = rsp_uns ? {16'b0, rsp_half} : {{16{rsp_half[15]}}, rsp_half};
            default: rsp_data = rsp_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: one op in flight, single-outstanding memory port, timeout abort; pass 1 / store 2 / load 3 cycles best case.
// Holds in_ready low outside IDLE and out_valid until out_ready; MEM_STAGE_MISALIGN_TRAP_EN enables misaligned H/W traps.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        reset,
    mem_stage_if.slave  bus
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

    state_e      state;
    logic [7:0]  tmo_cnt;
    logic        op_load;
    logic [4:0]  op_rd;
    logic [2:0]  op_funct3;
    logic [1:0]  op_alo;

    logic        in_ready_r;
    logic        mem_valid_r;
    logic [31:0] mem_addr_r;
    logic [3:0]  mem_wstrb_r;
    logic [31:0] mem_wdata_r;
    logic        out_valid_r;
    logic [31:0] out_data_r;
    logic [4:0]  out_rd_r;
    logic        bus_err_r;

    logic [3:0]  al_strb;
    logic [31:0] al_lanes;
    logic [31:0] al_ld;
    logic        is_mem;
    logic        is_store;
    logic        trap;
    logic        tmo_hit;

    mem_align u_align (
        .req_funct3 (bus.in_funct3),
        .req_alo    (bus.in_addr[1:0]),
        .req_data   (bus.in_wdata),
        .req_strb   (al_strb),
        .req_lanes  (al_lanes),
        .rsp_funct3 (op_funct3),
        .rsp_alo    (op_alo),
        .rsp_rdata  (bus.mem_rdata),
        .rsp_data   (al_ld)
    );

    assign is_store = (bus.in_kind == KIND_STORE);
    assign is_mem   = (bus.in_kind == KIND_LOAD) || is_store;
    assign tmo_hit  = (tmo_cnt == TMO_LAST);

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    assign trap = is_misaligned(bus.in_funct3, bus.in_addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            tmo_cnt     <= 8'd0;
            op_load     <= 1'b0;
            op_rd       <= 5'd0;
            op_funct3   <= 3'd0;
            op_alo      <= 2'd0;
            in_ready_r  <= 1'b0;
            mem_valid_r <= 1'b0;
            mem_addr_r  <= 32'd0;
            mem_wstrb_r <= 4'd0;
            mem_wdata_r <= 32'd0;
            out_valid_r <= 1'b0;
            out_data_r  <= 32'd0;
            out_rd_r    <= 5'd0;
            bus_err_r   <= 1'b0;
        end else begin
            bus_err_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    in_ready_r <= 1'b1;
                    if (bus.in_valid && in_ready_r) begin
                        in_ready_r <= 1'b0;
                        op_load    <= (bus.in_kind == KIND_LOAD);
                        op_rd      <= bus.in_rd;
                        op_funct3  <= bus.in_funct3;
                        op_alo     <= bus.in_addr[1:0];
                        if (!is_mem) begin
                            out_valid_r <= 1'b1;
                            out_data_r  <= bus.in_addr;
                            out_rd_r    <= bus.in_rd;
                            state       <= S_RESP;
                        end else if (trap) begin
                            out_valid_r <= 1'b1;
                            bus_err_r   <= 1'b1;
                            out_data_r  <= 32'd0;
                            out_rd_r    <= 5'd0;
                            state       <= S_RESP;
                        end else begin
                            mem_valid_r <= 1'b1;
                            mem_addr_r  <= {bus.in_addr[31:2], 2'b00};
                            mem_wstrb_r <= is_store ? al_strb : 4'b0000;
                            mem_wdata_r <= is_store ? al_lanes : 32'd0;
                            tmo_cnt     <= 8'd0;
                            state       <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (bus.mem_ready) begin
                        mem_valid_r <= 1'b0;
                        mem_wstrb_r <= 4'b0000;
                        tmo_cnt     <= 8'd0;
                        if (op_load) begin
                            state <= S_WAIT;
                        end else begin
                            out_valid_r <= 1'b1;
                            out_data_r  <= 32'd0;
                            out_rd_r    <= 5'd0;
                            state       <= S_RESP;
                        end
                    end else if (tmo_hit) begin
                        mem_valid_r <= 1'b0;
                        mem_wstrb_r <= 4'b0000;
                        out_valid_r <= 1'b1;
                        bus_err_r   <= 1'b1;
                        out_data_r  <= 32'd0;
                        out_rd_r    <= 5'd0;
                        state       <= S_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                S_WAIT: begin
                    if (bus.mem_rvalid) begin
                        out_valid_r <= 1'b1;
                        out_data_r  <= al_ld;
                        out_rd_r    <= op_rd;
                        state       <= S_RESP;
                    end else if (tmo_hit) begin
                        out_valid_r <= 1'b1;
                        bus_err_r   <= 1'b1;
                        out_data_r  <= 32'd0;
                        out_rd_r    <= 5'd0;
                        state       <= S_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        out_data_r  <= 32'd0;
                        out_rd_r    <= 5'd0;
                        in_ready_r  <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.mem_valid = mem_valid_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wstrb = mem_wstrb_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_rd    = out_rd_r;
    assign bus.bus_err   = bus_err_r;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed ops with a result scoreboard and an inline memory responder.
module tb_mem_stage;

    localparam int NEVER = 1000;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        err;
    } exp_t;

    logic clk;
    logic reset;
    mem_stage_if bus ();

    mem_stage #(.TIMEOUT_CYC(255)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    int   req_cnt = 0;
    int   ov_rise = 0;
    logic ov_prev = 1'b0;
    logic mv_prev = 1'b0;
    exp_t mon_e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            ov_prev = 1'b0;
            mv_prev = 1'b0;
        end else begin
            if (bus.mem_valid && !mv_prev) req_cnt++;
            if (bus.out_valid && !ov_prev) begin
                ov_rise++;
                if (sb.size() == 0) begin
                    check("unexpected_out", bus.out_valid, 1'b0);
                end else begin
                    mon_e = sb.pop_front();
                    check("out_data", bus.out_data, mon_e.data);
                    check("out_rd", 32'(bus.out_rd), 32'(mon_e.rd));
                    check("bus_err", bus.bus_err, mon_e.err);
                end
            end else if (bus.bus_err) begin
                check("bus_err_stray", bus.bus_err, 1'b0);
            end
            ov_prev = bus.out_valid;
            mv_prev = bus.mem_valid;
        end
    end

    task automatic run_op(
        input logic [1:0]  kind,      input logic [2:0]  f3,
        input logic [31:0] addr,      input logic [31:0] wdata,     input logic [4:0] rd,
        input logic        exp_req,   input logic [31:0] exp_maddr,
        input logic [3:0]  exp_strb,  input logic [31:0] exp_mwdata,
        input int          rdy_dly,   input int          rv_dly,    input logic [31:0] rdata,
        input logic [31:0] exp_data,  input logic [4:0]  exp_rd,    input logic exp_err,
        input int          hold_out
    );
        int   n;
        int   req0;
        exp_t e;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.in_ready && n < 10);
        check("in_ready", bus.in_ready, 1'b1);
        bus.in_valid  = 1'b1;
        bus.in_kind   = kind;
        bus.in_funct3 = f3;
        bus.in_addr   = addr;
        bus.in_wdata  = wdata;
        bus.in_rd     = rd;
        e.data = exp_data; e.rd = exp_rd; e.err = exp_err;
        sb.push_back(e);
        req0 = req_cnt;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        if (exp_req) begin
            n = 0;
            do begin @(negedge clk); n++; end while (!bus.mem_valid && n < 5);
            check("mem_valid", bus.mem_valid, 1'b1);
            check("mem_addr", bus.mem_addr, exp_maddr);
            check("mem_wstrb", 32'(bus.mem_wstrb), 32'(exp_strb));
            if (exp_strb != 4'b0000) check("mem_wdata", bus.mem_wdata, exp_mwdata);
            if (rdy_dly < NEVER) begin
                repeat (rdy_dly) @(negedge clk);
                if (rdy_dly > 0) check("mem_addr_hold", bus.mem_addr, exp_maddr);
                bus.mem_ready = 1'b1;
                @(posedge clk); #1;
                bus.mem_ready = 1'b0;
                @(negedge clk);
                check("mem_valid_drop", bus.mem_valid, 1'b0);
                if (exp_strb == 4'b0000 && rv_dly < NEVER) begin
                    repeat (rv_dly) @(negedge clk);
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = rdata;
                    @(posedge clk); #1;
                    bus.mem_rvalid = 1'b0;
                    bus.mem_rdata  = 32'd0;
                end
            end
        end
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.out_valid && n < 400);
        check("out_valid", bus.out_valid, 1'b1);
        repeat (hold_out) @(negedge clk);
        if (hold_out > 0) begin
            check("out_hold_data", bus.out_data, exp_data);
            check("out_hold_rd", 32'(bus.out_rd), 32'(exp_rd));
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("mem_req_cnt", 32'(req_cnt - req0), 32'(exp_req));
        check("mem_idle", bus.mem_valid, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rise0;
        int n;
        reset          = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_kind    = 2'b00;
        bus.in_funct3  = 3'b000;
        bus.in_addr    = 32'd0;
        bus.in_wdata   = 32'd0;
        bus.in_rd      = 5'd0;
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'd0;
        bus.out_ready  = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_mem_valid", bus.mem_valid, 1'b0);
        check("rst_mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_data", bus.out_data, 32'd0);
        check("rst_out_rd", 32'(bus.out_rd), 32'd0);
        check("rst_bus_err", bus.bus_err, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", bus.in_ready, 1'b1);

        // kind, f3, addr, wdata, rd, req, maddr, strb, mwdata, rdy, rv, rdata, data, rd, err, hold
        run_op(2'b00, 3'b000, 32'h0000_1234, 32'h0,          5'd5,  1'b0, 32'h0,          4'b0000, 32'h0,          0, 0, 32'h0,          32'h0000_1234, 5'd5,  1'b0, 0);
        run_op(2'b11, 3'b010, 32'hDEAD_BEEF, 32'h0,          5'd31, 1'b0, 32'h0,          4'b0000, 32'h0,          0, 0, 32'h0,          32'hDEAD_BEEF, 5'd31, 1'b0, 2);
        run_op(2'b10, 3'b000, 32'h8000_0003, 32'h1234_56AB,  5'd7,  1'b1, 32'h8000_0000,  4'b1000, 32'hABAB_ABAB,  0, 0, 32'h0,          32'h0,         5'd0,  1'b0, 0);
        run_op(2'b10, 3'b001, 32'h8000_0006, 32'h0000_BEEF,  5'd7,  1'b1, 32'h8000_0004,  4'b1100, 32'hBEEF_BEEF,  2, 0, 32'h0,          32'h0,         5'd0,  1'b0, 0);
        run_op(2'b10, 3'b010, 32'h0000_1000, 32'h0123_4567,  5'd2,  1'b1, 32'h0000_1000,  4'b1111, 32'h0123_4567,  0, 0, 32'h0,          32'h0,         5'd0,  1'b0, 1);
        run_op(2'b10, 3'b111, 32'h0000_1008, 32'h89AB_CDEF,  5'd2,  1'b1, 32'h0000_1008,  4'b1111, 32'h89AB_CDEF,  0, 0, 32'h0,          32'h0,         5'd0,  1'b0, 0);
        run_op(2'b01, 3'b000, 32'h0000_2001, 32'h0,          5'd3,  1'b1, 32'h0000_2000,  4'b0000, 32'h0,          0, 0, 32'h0000_8000, 32'hFFFF_FF80, 5'd3,  1'b0, 0);
        run_op(2'b01, 3'b100, 32'h0000_2001, 32'h0,          5'd3,  1'b1, 32'h0000_2000,  4'b0000, 32'h0,          1, 0, 32'h0000_8000, 32'h0000_0080, 5'd3,  1'b0, 0);
        run_op(2'b01, 3'b101, 32'h0000_2002, 32'h0,          5'd8,  1'b1, 32'h0000_2000,  4'b0000, 32'h0,          0, 3, 32'hBEEF_0000, 32'h0000_BEEF, 5'd8,  1'b0, 0);
        run_op(2'b01, 3'b001, 32'h0000_2002, 32'h0,          5'd9,  1'b1, 32'h0000_2000,  4'b0000, 32'h0,          0, 0, 32'hBEEF_0000, 32'hFFFF_BEEF, 5'd9,  1'b0, 2);
        run_op(2'b01, 3'b000, 32'h0000_2003, 32'h0,          5'd10, 1'b1, 32'h0000_2000,  4'b0000, 32'h0,          0, 1, 32'h7F00_0000, 32'h0000_007F, 5'd10, 1'b0, 0);
        run_op(2'b01, 3'b011, 32'h0000_3000, 32'h0,          5'd11, 1'b1, 32'h0000_3000,  4'b0000, 32'h0,          0, 0, 32'h89AB_CDEF, 32'h89AB_CDEF, 5'd11, 1'b0, 0);
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        run_op(2'b01, 3'b010, 32'h1000_0002, 32'h0,          5'd4,  1'b0, 32'h0,          4'b0000, 32'h0,          0, 0, 32'h0,          32'h0,         5'd0,  1'b1, 0);
        run_op(2'b10, 3'b001, 32'h8000_0001, 32'h0000_1234,  5'd6,  1'b0, 32'h0,          4'b0000, 32'h0,          0, 0, 32'h0,          32'h0,         5'd0,  1'b1, 0);
`else
        run_op(2'b01, 3'b010, 32'h1000_0002, 32'h0,          5'd4,  1'b1, 32'h1000_0000,  4'b0000, 32'h0,          0, 0, 32'hCAFE_BABE, 32'hCAFE_BABE, 5'd4,  1'b0, 0);
        run_op(2'b10, 3'b001, 32'h8000_0001, 32'h0000_1234,  5'd6,  1'b1, 32'h8000_0000,  4'b0011, 32'h1234_1234,  0, 0, 32'h0,          32'h0,         5'd0,  1'b0, 0);
`endif
        // Timeouts: memory never accepts, then accepts but never returns data.
        run_op(2'b10, 3'b010, 32'h0000_4000, 32'h5555_AAAA,  5'd12, 1'b1, 32'h0000_4000,  4'b1111, 32'h5555_AAAA,  NEVER, 0, 32'h0,      32'h0,         5'd0,  1'b1, 0);
        run_op(2'b01, 3'b010, 32'h0000_5000, 32'h0,          5'd13, 1'b1, 32'h0000_5000,  4'b0000, 32'h0,          0, NEVER, 32'h0,      32'h0,         5'd0,  1'b1, 0);
        run_op(2'b00, 3'b000, 32'h0000_0042, 32'h0,          5'd1,  1'b0, 32'h0,          4'b0000, 32'h0,          0, 0, 32'h0,          32'h0000_0042, 5'd1,  1'b0, 0);

        // Reset while waiting for load data: op dropped, late rvalid ignored.
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.in_ready && n < 10);
        check("wait_rst_in_ready", bus.in_ready, 1'b1);
        bus.in_valid  = 1'b1;
        bus.in_kind   = 2'b01;
        bus.in_funct3 = 3'b010;
        bus.in_addr   = 32'h0000_6000;
        bus.in_rd     = 5'd14;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("wait_rst_mem_valid", bus.mem_valid, 1'b1);
        bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        rise0 = ov_rise;
        @(negedge clk);
        check("mid_rst_in_ready", bus.in_ready, 1'b0);
        check("mid_rst_out_valid", bus.out_valid, 1'b0);
        check("mid_rst_mem_valid", bus.mem_valid, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1357_9BDF;
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0;
        repeat (5) @(negedge clk);
        check("late_rvalid_no_out", 32'(ov_rise - rise0), 32'd0);
        check("late_rvalid_in_ready", bus.in_ready, 1'b1);

        run_op(2'b00, 3'b000, 32'hA5A5_0001, 32'h0,          5'd15, 1'b0, 32'h0,          4'b0000, 32'h0,          0, 0, 32'h0,          32'hA5A5_0001, 5'd15, 1'b0, 0);
        check("sb_drain", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
